// File: rtl/sram_access_master_if.sv
// Core request/response and program SRAM bus bundle
// for the SRAM access master.
interface sram_access_master_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          cs_d;
  logic          wd;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          is_coming;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  dout, is_coming,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output cs_d, wd, rd, addr, din
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output dout, is_coming,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  cs_d, wd, rd, addr, din
  );
endinterface

// File: rtl/sram_access_master.sv
// CPU-side initiator for the 256x16 program SRAM:
// single read/write per request, read timeout.
module sram_access_master #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_access_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

  state_t        state;
  state_t        nxt_state;
  logic [3:0]    cnt;
  logic [3:0]    nxt_cnt;
  logic          nxt_cs;
  logic          nxt_wd;
  logic          nxt_rd;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_din;
  logic          nxt_vld;
  logic [DW-1:0] nxt_rdata;
  logic          nxt_err;

  assign bus.req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.cs_d      <= 1'b1;
      bus.wd        <= 1'b0;
      bus.rd        <= 1'b0;
      bus.addr      <= '0;
      bus.din       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      bus.cs_d      <= nxt_cs;
      bus.wd        <= nxt_wd;
      bus.rd        <= nxt_rd;
      bus.addr      <= nxt_addr;
      bus.din       <= nxt_din;
      bus.rsp_valid <= nxt_vld;
      bus.rsp_rdata <= nxt_rdata;
      bus.rsp_err   <= nxt_err;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_cs    = bus.cs_d;
    nxt_wd    = bus.wd;
    nxt_rd    = bus.rd;
    nxt_addr  = bus.addr;
    nxt_din   = bus.din;
    nxt_vld   = 1'b0;
    nxt_rdata = bus.rsp_rdata;
    nxt_err   = bus.rsp_err;
    unique case (state)
      IDLE: begin
        nxt_cs = 1'b1;
        nxt_wd = 1'b0;
        nxt_rd = 1'b0;
        if (bus.req_valid && bus.req_ready) begin
          nxt_addr = bus.req_addr;
          nxt_cs   = 1'b0;
          if (bus.req_we) begin
            nxt_din   = bus.req_wdata;
            nxt_wd    = 1'b1;
            nxt_state = WRITE;
          end else begin
            nxt_rd    = 1'b1;
            nxt_cnt   = '0;
            nxt_state = READ;
          end
        end
      end
      WRITE: begin
        nxt_cs    = 1'b1;
        nxt_wd    = 1'b0;
        nxt_vld   = 1'b1;
        nxt_err   = 1'b0;
        nxt_state = IDLE;
      end
      READ: begin
        nxt_cnt = cnt + 4'd1;
        // cnt==0 means rd not yet sampled: is_coming is stale
        if (cnt != '0 && bus.is_coming) begin
          nxt_rdata = bus.dout;
          nxt_vld   = 1'b1;
          nxt_err   = 1'b0;
          nxt_cs    = 1'b1;
          nxt_rd    = 1'b0;
          nxt_state = IDLE;
        end else if (cnt == LAST) begin
          nxt_rdata = '0;
          nxt_vld   = 1'b1;
          nxt_err   = 1'b1;
          nxt_cs    = 1'b1;
          nxt_rd    = 1'b0;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_access_master.sv
// Directed bench for sram_access_master with a
// one-cycle SRAM model and a write scoreboard.
module tb_sram_access_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   dead = 1'b0;

  always #5 clk = ~clk;

  sram_access_master_if bus ();

  sram_access_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [256];
  logic [15:0] sram_q = '0;
  logic        sram_hit = 1'b0;

  // read data and valid are sticky until the next sampled rd
  always @(posedge clk) begin
    if (!bus.cs_d && bus.wd) mem[bus.addr] <= bus.din;
    if (!bus.cs_d && bus.rd) begin
      sram_q   <= mem[bus.addr];
      sram_hit <= 1'b1;
    end
  end

  assign bus.dout      = sram_q;
  assign bus.is_coming = sram_hit && !dead;

  int vectors    = 0;
  int miscompares = 0;
  int n_acc      = 0;
  int n_rsp      = 0;
  int aborted    = 0;
  int rd_cycles  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) n_acc++;
      if (bus.rsp_valid) n_rsp++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic legal;
    @(posedge clk);
    #1;
    legal = (bus.cs_d && !bus.wd && !bus.rd) ||
            (!bus.cs_d && (bus.wd ^ bus.rd));
    check("proto", 32'(legal), 32'd1);
    if (bus.rd) rd_cycles++;
  endtask

  task automatic xact(input  logic        we,
                      input  logic [7:0]  a,
                      input  logic [15:0] d,
                      output logic [15:0] rdata,
                      output logic        err,
                      output int          lat);
    int w;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      tick();
      w++;
    end
    check("accept", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rdata;
    logic        err;
    int          lat;
    logic [15:0] sb [256];
    bit          ok [256];
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;

    for (int i = 0; i < 256; i++) ok[i] = 1'b0;

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h33;
    bus.req_wdata = 16'h0;

    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      tick();
      check("rst_cs", 32'(bus.cs_d), 32'd1);
      check("rst_wd", 32'(bus.wd), 32'd0);
      check("rst_rd", 32'(bus.rd), 32'd0);
      check("rst_vld", 32'(bus.rsp_valid), 32'd0);
      check("rst_addr", 32'(bus.addr), 32'd0);
      check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(bus.req_ready), 32'd1);

    xact(1'b1, 8'h12, 16'hBEEF, rdata, err, lat);
    sb[8'h12] = 16'hBEEF; ok[8'h12] = 1'b1;
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_err", 32'(err), 32'd0);
    xact(1'b0, 8'h12, 16'h0, rdata, err, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", 32'(rdata), 32'hBEEF);
    check("rd_err", 32'(err), 32'd0);

    xact(1'b1, 8'h00, 16'h1111, rdata, err, lat);
    sb[8'h00] = 16'h1111; ok[8'h00] = 1'b1;
    xact(1'b1, 8'hFF, 16'h2222, rdata, err, lat);
    sb[8'hFF] = 16'h2222; ok[8'hFF] = 1'b1;

    // back-to-back reads with req_valid held high
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    check("b2b_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_addr = 8'hFF;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b1_lat", 32'(lat), 32'd3);
    check("b2b1_data", 32'(bus.rsp_rdata), 32'h1111);
    check("b2b1_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b2_lat", 32'(lat), 32'd3);
    check("b2b2_data", 32'(bus.rsp_rdata), 32'h2222);
    check("b2b2_err", 32'(bus.rsp_err), 32'd0);

    dead = 1'b1;
    rd_cycles = 0;
    xact(1'b0, 8'h05, 16'h0, rdata, err, lat);
    check("to_err", 32'(err), 32'd1);
    check("to_data", 32'(rdata), 32'd0);
    check("to_lat", 32'(lat), 32'd5);
    check("to_rd_cycles", 32'(rd_cycles), 32'd4);
    check("to_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("to_pulse", 32'(bus.rsp_valid), 32'd0);
    dead = 1'b0;

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h12;
    tick();
    bus.req_valid = 1'b0;
    check("mid_rd_on", 32'(bus.rd), 32'd1);
    rst = 1'b1;
    tick();
    aborted++;
    check("mid_rd_off", 32'(bus.rd), 32'd0);
    check("mid_cs", 32'(bus.cs_d), 32'd1);
    check("mid_vld", 32'(bus.rsp_valid), 32'd0);
    check("mid_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("mid_novld", 32'(bus.rsp_valid), 32'd0);
    xact(1'b1, 8'h20, 16'hCAFE, rdata, err, lat);
    sb[8'h20] = 16'hCAFE; ok[8'h20] = 1'b1;
    check("post_wr_lat", 32'(lat), 32'd2);
    check("post_wr_err", 32'(err), 32'd0);
    xact(1'b0, 8'h20, 16'h0, rdata, err, lat);
    check("post_rd_data", 32'(rdata), 32'hCAFE);

    for (int i = 0; i < 1000; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 8'hFF
                                       : 8'($urandom_range(0, 31));
      d  = 16'($urandom);
      xact(we, a, d, rdata, err, lat);
      check("rnd_err", 32'(err), 32'd0);
      if (we) begin
        sb[a] = d;
        ok[a] = 1'b1;
        check("rnd_wr_lat", 32'(lat), 32'd2);
      end else begin
        check("rnd_rd_lat", 32'(lat), 32'd3);
        if (ok[a]) check("rnd_rd_data", 32'(rdata), 32'(sb[a]));
      end
      for (int j = $urandom_range(0, 2); j > 0; j--) tick();
    end

    tick();
    tick();
    check("rsp_count", 32'(n_rsp), 32'(n_acc - aborted));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
